// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Front-end of the board's 4-bit ALU. A debounced load button steps through
// operand entry (A, then B, then opcode) taken from the slide switches. The
// registered operands drive the ALU. One cycle later the ALU result and flags
// are captured for the seven-segment display path. A debounced clear button
// returns entry to A and zeroes every value.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   sw_data    in   4  switch value loaded as A or B
//   sw_op      in   3  switch value loaded as ALU ctrl
//   btn_load   in   1  raw bouncing load button (active-high)
//   btn_clr    in   1  raw bouncing clear button (active-high)
//   alu_a      out  4  registered operand A
//   alu_b      out  4  registered operand B
//   alu_ctrl   out  3  registered opcode
//   alu_res    in   4  ALU combinational result
//   alu_car    in   1  ALU carry flag
//   alu_of     in   1  ALU overflow flag
//   res_q      out  4  captured result
//   car_q      out  1  captured carry
//   of_q       out  1  captured overflow
//   res_valid  out  1  captured values hold a completed operation
//   step       out  2  entry step: 0=A, 1=B, 2=OP, 3=EXEC/SHOW
// -----------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_data,
    input  logic [2:0] sw_op,
    input  logic       btn_load,
    input  logic       btn_clr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_res,
    input  logic       alu_car,
    input  logic       alu_of,
    output logic [3:0] res_q,
    output logic       car_q,
    output logic       of_q,
    output logic       res_valid,
    output logic [1:0] step
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // Index 0 = load button, index 1 = clear button.
    logic [1:0]    w_btn_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_level;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_rise;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_alu_a,    w_alu_a_nxt;
    logic [3:0]    r_alu_b,    w_alu_b_nxt;
    logic [2:0]    r_alu_ctrl, w_alu_ctrl_nxt;
    logic [3:0]    r_res,      w_res_nxt;
    logic          r_car,      w_car_nxt;
    logic          r_of,       w_of_nxt;
    logic          r_valid,    w_valid_nxt;
    logic [1:0]    r_step,     w_step_nxt;

    assign w_btn_raw = {btn_clr, btn_load};

    // Synchronise both buttons and accept a new level only after it has been
    // continuously different from the accepted one for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_level <= 2'b00;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else if (r_cnt[i] != CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Press pulse: the single cycle in which an accepted level flips 0 -> 1.
    always_comb begin
        w_rise = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_rise[i] = r_sync2[i] & ~r_level[i] & (r_cnt[i] == CNT_LAST);
        end
    end

    // Entry sequencing: next state and next values of every held register.
    always_comb begin
        w_state_nxt    = r_state;
        w_alu_a_nxt    = r_alu_a;
        w_alu_b_nxt    = r_alu_b;
        w_alu_ctrl_nxt = r_alu_ctrl;
        w_res_nxt      = r_res;
        w_car_nxt      = r_car;
        w_of_nxt       = r_of;
        w_valid_nxt    = r_valid;
        if (w_rise[1]) begin
            // Clear outranks a simultaneous load.
            w_state_nxt    = LOAD_A;
            w_alu_a_nxt    = 4'd0;
            w_alu_b_nxt    = 4'd0;
            w_alu_ctrl_nxt = 3'd0;
            w_res_nxt      = 4'd0;
            w_car_nxt      = 1'b0;
            w_of_nxt       = 1'b0;
            w_valid_nxt    = 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_rise[0]) begin
                        w_alu_a_nxt = sw_data;
                        w_state_nxt = LOAD_B;
                    end else begin
                        w_state_nxt = LOAD_A;
                    end
                end
                LOAD_B: begin
                    if (w_rise[0]) begin
                        w_alu_b_nxt = sw_data;
                        w_state_nxt = LOAD_OP;
                    end else begin
                        w_state_nxt = LOAD_B;
                    end
                end
                LOAD_OP: begin
                    if (w_rise[0]) begin
                        w_alu_ctrl_nxt = sw_op;
                        w_state_nxt    = EXEC;
                    end else begin
                        w_state_nxt = LOAD_OP;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle here.
                    w_res_nxt   = alu_res;
                    w_car_nxt   = alu_car;
                    w_of_nxt    = alu_of;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SHOW;
                end
                SHOW: begin
                    if (w_rise[0]) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = LOAD_A;
                    end else begin
                        w_state_nxt = SHOW;
                    end
                end
                default: begin
                    w_state_nxt = LOAD_A;
                end
            endcase
        end
    end

    // LED step code follows the state being entered so it is registered too.
    always_comb begin
        case (w_state_nxt)
            LOAD_A:  w_step_nxt = 2'd0;
            LOAD_B:  w_step_nxt = 2'd1;
            LOAD_OP: w_step_nxt = 2'd2;
            EXEC:    w_step_nxt = 2'd3;
            SHOW:    w_step_nxt = 2'd3;
            default: w_step_nxt = 2'd0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD_A;
            r_alu_a    <= 4'd0;
            r_alu_b    <= 4'd0;
            r_alu_ctrl <= 3'd0;
            r_res      <= 4'd0;
            r_car      <= 1'b0;
            r_of       <= 1'b0;
            r_valid    <= 1'b0;
            r_step     <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_ctrl <= w_alu_ctrl_nxt;
            r_res      <= w_res_nxt;
            r_car      <= w_car_nxt;
            r_of       <= w_of_nxt;
            r_valid    <= w_valid_nxt;
            r_step     <= w_step_nxt;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_ctrl  = r_alu_ctrl;
    assign res_q     = r_res;
    assign car_q     = r_car;
    assign of_q      = r_of;
    assign res_valid = r_valid;
    assign step      = r_step;

endmodule
